// File: rtl/dmem_responder.sv
// Word-addressed data memory behind the MEM-stage load/store port, with WAIT_STATES extra cycles per access.
// Optional `DMEM_ALIGN_CHECK_EN adds a misaligned output and suppresses accesses whose address[1:0] is nonzero.
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        mem_stall,
`ifdef DMEM_ALIGN_CHECK_EN
    output logic        misaligned,
`endif
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam bit         ZERO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0] CNT_INIT  = ZERO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t state, state_nxt;
    logic [3:0] cnt;
    logic req;

    logic [ADDR_W-1:0] lat_idx;
    logic [31:0]       lat_wdata;
    logic              lat_rd, lat_wr, lat_mis;

    logic [ADDR_W-1:0] acc_idx;
    logic [31:0]       acc_wdata;
    logic              acc_rd, acc_wr, acc_mis, do_access;

    logic [31:0] mem [DEPTH] = '{default: '0};

    // Upper address bits wrap; low bits only matter to the alignment check.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{address[31:ADDR_W+2], address[1:0]};

    assign req = MemRead | MemWrite;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req) state_nxt = ZERO_WAIT ? S_DONE : S_WAIT;
            S_WAIT:  if (cnt == 4'd0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_stall = req && (state != S_DONE);
        done      = (state == S_DONE);
    end

    // With zero wait states the access happens on the accepting edge, so it uses the live inputs.
    always_comb begin
        acc_idx   = lat_idx;
        acc_wdata = lat_wdata;
        acc_rd    = lat_rd;
        acc_wr    = lat_wr;
        acc_mis   = lat_mis;
        do_access = 1'b0;
        if (state == S_IDLE) begin
            acc_idx   = address[ADDR_W+1:2];
            acc_wdata = write_data;
            acc_rd    = MemRead;
            acc_wr    = MemWrite;
`ifdef DMEM_ALIGN_CHECK_EN
            acc_mis   = (address[1:0] != 2'b00);
`else
            acc_mis   = 1'b0;
`endif
            do_access = req && ZERO_WAIT;
        end else if (state == S_WAIT) begin
            do_access = (cnt == 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= 4'd0;
            read_data <= 32'd0;
            lat_idx   <= '0;
            lat_wdata <= 32'd0;
            lat_rd    <= 1'b0;
            lat_wr    <= 1'b0;
            lat_mis   <= 1'b0;
        end else begin
            if (state == S_IDLE && req) begin
                lat_idx   <= acc_idx;
                lat_wdata <= acc_wdata;
                lat_rd    <= acc_rd;
                lat_wr    <= acc_wr;
                lat_mis   <= acc_mis;
                cnt       <= CNT_INIT;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            // Read-before-write: the nonblocking read sees the pre-store word.
            if (do_access && (acc_rd || acc_mis))
                read_data <= acc_mis ? 32'd0 : mem[acc_idx];
        end
    end

    // Backing store survives reset; reset only blocks a store on its own edge.
    always_ff @(posedge clk) begin
        if (!reset && do_access && acc_wr && !acc_mis)
            mem[acc_idx] <= acc_wdata;
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic mis_q;

    always_ff @(posedge clk) begin
        if (reset)          mis_q <= 1'b0;
        else if (do_access) mis_q <= acc_mis;
    end

    assign misaligned = done && mis_q;
`endif

endmodule
